// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 6;
    localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;
    localparam int PC_STEP    = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries; flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = INSTR_W + 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !flush && !empty;
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: req/ack fetch FSM feeding a prefetch FIFO.
// Build option FETCH_STATS_EN adds saturating fetch/flush statistics ports.
//
// state   | meaning
// IDLE    | no request outstanding; waiting for FIFO room
// REQ     | right-path request outstanding at the fetch PC
// DISCARD | wrong-path request outstanding; its data is dropped, then fetch target
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    input  logic                stall,
    output logic                instr_valid,
    output logic [INSTR_W-1:0]  instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   instr_pc
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]         stat_fetched,
    output logic [31:0]         stat_flushed
`endif
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int               ENTRY_W   = INSTR_W + ADDR_W;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FIFO_DEPTH - 1);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] target_q;
    logic [ADDR_W-1:0] target_d;
    logic [ADDR_W-1:0] redir_pc;
    logic              push;
    logic              pop;
    logic              ack_dropped;
    logic              room_after_push;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic [ENTRY_W-1:0] head;

    assign redir_pc    = redirect_pc & ~ADDR_W'(1);
    assign instr_valid = !empty;
    assign pop         = instr_valid && !stall && !redirect;
    assign imem_req    = (state_q != ST_IDLE);
    assign imem_addr   = addr_q;

    // Any pop this cycle leaves a slot; otherwise the push must not take the last one.
    assign room_after_push = pop || (count < LAST_SLOT);

    assign instr    = instr_valid ? head[ENTRY_W-1 -: INSTR_W] : '0;
    assign instr_pc = instr_valid ? head[ADDR_W-1:0] : '0;
    assign opcode   = instr[OPCODE_MSB:OPCODE_LSB];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_rdata, addr_q}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= RESET_PC;
            target_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            target_q <= target_d;
        end
    end

    // addr_q doubles as the fetch PC and is only moved once the current request acks.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        target_d    = target_q;
        push        = 1'b0;
        ack_dropped = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    addr_d  = redir_pc;
                    state_d = ST_REQ;
                end else if (!full) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        ack_dropped = 1'b1;
                        addr_d      = redir_pc;
                        state_d     = ST_REQ;
                    end else begin
                        push    = 1'b1;
                        addr_d  = addr_q + ADDR_W'(PC_STEP);
                        state_d = room_after_push ? ST_REQ : ST_IDLE;
                    end
                end else if (redirect) begin
                    target_d = redir_pc;
                    state_d  = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (redirect) target_d = redir_pc;
                if (imem_ack) begin
                    ack_dropped = 1'b1;
                    addr_d      = redirect ? redir_pc : target_q;
                    state_d     = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FETCH_STATS_EN
    logic [32:0] fetched_sum;
    logic [32:0] flushed_sum;

    assign fetched_sum = {1'b0, stat_fetched} + 33'(push);
    assign flushed_sum = {1'b0, stat_flushed} + 33'(ack_dropped)
                       + (redirect ? 33'(count) : 33'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            stat_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
            stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end
`endif

endmodule
